// File: rtl/handshake_sender.sv
// Initiator side of a 4-phase request/confirm handshake, fed from a small FIFO.
// Words are presented on data_out one cycle before request rises and are retried after a timeout.
module handshake_sender #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load_data,
    input  logic       confirm,
    output logic       request,
    output logic [3:0] data_out,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic [7:0] sent_count,
    output logic       timeout_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_REQ,
        ST_RELEASE
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     mem_q [DEPTH];
    logic [3:0]     mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           full_q, full_d;
    logic           empty_q, empty_d;
    logic           request_q, request_d;
    logic [3:0]     data_out_q, data_out_d;
    logic [7:0]     wait_cnt_q, wait_cnt_d;
    logic [7:0]     sent_count_q, sent_count_d;
    logic           timeout_err_q, timeout_err_d;
    logic           push;
    logic           pop;

    always_comb begin
        state_d       = state_q;
        data_out_d    = data_out_q;
        wait_cnt_d    = wait_cnt_q;
        sent_count_d  = sent_count_q;
        timeout_err_d = timeout_err_q;
        pop           = 1'b0;
        // request is a registered decode of the current state, so it trails
        // the REQ state by one cycle and data_out leads it by one cycle
        request_d     = (state_q == ST_REQ);
        case (state_q)
            ST_IDLE: begin
                if (!empty_q) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                data_out_d = mem_q[rd_ptr_q];
                wait_cnt_d = '0;
                state_d    = ST_REQ;
            end
            ST_REQ: begin
                if (confirm) begin
                    pop     = 1'b1;
                    state_d = ST_RELEASE;
                end else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_RELEASE: begin
                if (!confirm) begin
                    sent_count_d = sent_count_q + 8'd1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        // a pop in the same cycle frees the slot, so a load while full is accepted
        push     = load && (!full_q || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = load_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            mem_q         <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            request_q     <= 1'b0;
            data_out_q    <= '0;
            wait_cnt_q    <= '0;
            sent_count_q  <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            request_q     <= request_d;
            data_out_q    <= data_out_d;
            wait_cnt_q    <= wait_cnt_d;
            sent_count_q  <= sent_count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign request     = request_q;
    assign data_out    = data_out_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign busy        = (state_q != ST_IDLE);
    assign sent_count  = sent_count_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_handshake_sender.sv
// Directed bench for handshake_sender: reset, single word, fill/overflow,
// timeout with retry, stuck confirm, reset mid-handshake, push+pop while full.
module tb_handshake_sender;

    logic       clock;
    logic       reset_n;
    logic       load;
    logic [3:0] load_data;
    logic       confirm;
    logic       request;
    logic [3:0] data_out;
    logic       full;
    logic       empty;
    logic       busy;
    logic [7:0] sent_count;
    logic       timeout_err;

    int checks;
    int errors;
    int exp_sent;

    handshake_sender #(.DEPTH(4), .TIMEOUT(15)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .load        (load),
        .load_data   (load_data),
        .confirm     (confirm),
        .request     (request),
        .data_out    (data_out),
        .full        (full),
        .empty       (empty),
        .busy        (busy),
        .sent_count  (sent_count),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        load    = 1'b0;
        confirm = 1'b0;
        tick();
        tick();
        reset_n  = 1'b1;
        exp_sent = 0;
    endtask

    task automatic load_word(input logic [3:0] w);
        load      = 1'b1;
        load_data = w;
        tick();
        load      = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (request !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check_eq("req_rise", {31'd0, request}, 32'd1);
    endtask

    task automatic finish_release(input string tag);
        int n;
        n = 0;
        while (request !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        check_eq({tag, "_req_fall"}, {31'd0, request}, 32'd0);
        tick();
        confirm = 1'b0;
        tick();
        exp_sent++;
        check_eq({tag, "_sent"}, {24'd0, sent_count}, 32'(exp_sent));
    endtask

    task automatic respond(input int delay, input logic [3:0] exp_word, input string tag);
        int n;
        wait_req(n);
        check_eq({tag, "_data"}, {28'd0, data_out}, {28'd0, exp_word});
        for (int i = 0; i < delay; i++) begin
            tick();
            check_eq({tag, "_hold"}, {28'd0, data_out}, {28'd0, exp_word});
        end
        confirm = 1'b1;
        finish_release(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        int hc;
        checks    = 0;
        errors    = 0;
        exp_sent  = 0;
        load_data = '0;

        // reset
        reset_dut();
        check_eq("rst_request", {31'd0, request}, 32'd0);
        check_eq("rst_data", {28'd0, data_out}, 32'd0);
        check_eq("rst_empty", {31'd0, empty}, 32'd1);
        check_eq("rst_full", {31'd0, full}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_sent", {24'd0, sent_count}, 32'd0);
        check_eq("rst_terr", {31'd0, timeout_err}, 32'd0);

        // single word, latency, confirm 2 cycles after request
        load_word(4'b0110);
        check_eq("t2_empty", {31'd0, empty}, 32'd0);
        wait_req(n);
        check_eq("t2_latency", 32'(n), 32'd3);
        respond(2, 4'b0110, "t2");
        check_eq("t2_empty_end", {31'd0, empty}, 32'd1);
        check_eq("t2_busy_end", {31'd0, busy}, 32'd0);

        // fill to full, fifth word dropped
        for (int i = 1; i <= 5; i++) begin
            load_word(4'(i));
            if (i == 3) check_eq("t3_notfull", {31'd0, full}, 32'd0);
            if (i == 4) check_eq("t3_full", {31'd0, full}, 32'd1);
        end
        check_eq("t3_full_after5", {31'd0, full}, 32'd1);
        for (int w = 1; w <= 4; w++) respond(0, 4'(w), "t3");
        check_eq("t3_empty", {31'd0, empty}, 32'd1);
        repeat (6) tick();
        check_eq("t3_no_extra_req", {31'd0, request}, 32'd0);
        check_eq("t3_idle", {31'd0, busy}, 32'd0);
        check_eq("t3_terr", {31'd0, timeout_err}, 32'd0);

        // timeout and retry
        load_word(4'b0111);
        wait_req(n);
        hc = 0;
        while (request === 1'b1 && hc < 40) begin
            tick();
            hc++;
        end
        check_eq("t4_req_cycles", 32'(hc), 32'd15);
        check_eq("t4_terr", {31'd0, timeout_err}, 32'd1);
        check_eq("t4_retained", {31'd0, empty}, 32'd0);
        respond(0, 4'b0111, "t4");
        check_eq("t4_empty", {31'd0, empty}, 32'd1);
        check_eq("t4_terr_sticky", {31'd0, timeout_err}, 32'd1);

        // confirm stuck high in RELEASE
        reset_dut();
        check_eq("t5_terr_cleared", {31'd0, timeout_err}, 32'd0);
        load_word(4'hA);
        wait_req(n);
        confirm = 1'b1;
        repeat (20) tick();
        check_eq("t5_request", {31'd0, request}, 32'd0);
        check_eq("t5_sent_held", {24'd0, sent_count}, 32'd0);
        check_eq("t5_terr", {31'd0, timeout_err}, 32'd0);
        check_eq("t5_busy", {31'd0, busy}, 32'd1);
        confirm = 1'b0;
        tick();
        check_eq("t5_sent", {24'd0, sent_count}, 32'd1);
        check_eq("t5_idle", {31'd0, busy}, 32'd0);

        // reset while in REQ with words queued
        reset_dut();
        load_word(4'h1);
        load_word(4'h2);
        load_word(4'h3);
        wait_req(n);
        check_eq("t6_data", {28'd0, data_out}, 32'h1);
        reset_n = 1'b0;
        tick();
        check_eq("t6_request", {31'd0, request}, 32'd0);
        check_eq("t6_empty", {31'd0, empty}, 32'd1);
        check_eq("t6_sent", {24'd0, sent_count}, 32'd0);
        check_eq("t6_busy", {31'd0, busy}, 32'd0);
        check_eq("t6_data_rst", {28'd0, data_out}, 32'd0);
        reset_n = 1'b1;

        // load and pop in the same cycle while full
        reset_dut();
        load_word(4'hA);
        load_word(4'hB);
        load_word(4'hC);
        load_word(4'hD);
        check_eq("t7_full", {31'd0, full}, 32'd1);
        wait_req(n);
        check_eq("t7_data_a", {28'd0, data_out}, 32'hA);
        confirm   = 1'b1;
        load      = 1'b1;
        load_data = 4'hE;
        tick();
        load      = 1'b0;
        check_eq("t7_full_kept", {31'd0, full}, 32'd1);
        finish_release("t7a");
        respond(0, 4'hB, "t7b");
        respond(0, 4'hC, "t7c");
        respond(0, 4'hD, "t7d");
        respond(0, 4'hE, "t7e");
        check_eq("t7_empty", {31'd0, empty}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
